md_seg_scan_4digit: RTL and testbench
=====================================

// Module: md_seg_scan_4digit
// PURPOSE
//  Consumes the 4-bit count values produced by the lab counters and drives a
//  4-digit multiplexed 7-segment display. Input data is double-buffered (pending
//  -> committed at frame boundary) so a frame never mixes old and new digits.
//  Sits directly downstream of the counter blocks, on the board clock.
// PARAMETERS
//  SCAN_DIV    50000  clk cycles per digit slot (>= 4)
//  DEAD_CYC    2      cycles at slot start with all anodes off (anti-ghost), < SCAN_DIV
//  ACTIVE_LOW  1      1: seg/dp/an are active-low; 0: active-high
//  BLANK_LZ    1      1: blank leading zero digits 3..1
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  din_valid   in   1   one-cycle strobe: capture din/dp_in into pending buffer
//  din         in   16  four hex digits, din[3:0] = digit0 (rightmost)
//  dp_in       in   4   decimal point per digit, bit i = digit i
//  seg         out  7   {g,f,e,d,c,b,a}, registered
//  dp          out  1   decimal point of active digit, registered
//  an          out  4   digit enables, an[i] = digit i, registered, one-hot when on
//  frame_done  out  1   one-cycle pulse at each commit/frame start, registered
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high. Reset values: pending=0,
//    committed=0, div_cnt=0, idx=0; an/seg/dp = all inactive (ACTIVE_LOW=1:
//    an=4'hF, seg=7'h7F, dp=1); frame_done=0. rst mid-operation: all of the above
//    on the next edge; pending data is discarded.
//  - Divider: div_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 wraps to 0 and idx
//    increments mod 4 (3 -> 0 wraps).
//  - Commit: on the edge where idx wraps 3->0, committed <= pending. If din_valid
//    is high in that same cycle, the new din/dp_in are committed directly (bypass)
//    and also written to pending. din_valid at any other time only updates pending.
//  - frame_done = 1 in exactly the cycle where idx==0 and div_cnt==0 following a
//    wrap; not asserted for the first slot after reset.
//  - Output stage (1-cycle latency from idx/div_cnt): if div_cnt < DEAD_CYC all
//    anodes off; else an[idx] on, others off. seg = hex2seg(committed digit idx),
//    dp = committed dp bit idx (polarity per ACTIVE_LOW).
//  - Hex decode 0-F standard (active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D
//    7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71).
//  - Leading-zero blanking (BLANK_LZ=1): digit k (3..1) shows all segments off
//    (anode still driven) when digit k and every higher digit are 0; digit 0 is
//    never blanked. dp of a blanked digit still follows dp_in.
//  - Widths: div_cnt = $clog2(SCAN_DIV) bits; idx 2 bits, natural wrap.
// STRUCTURE
//  - Package md_seg_pkg: NUM_DIG=4, 16-entry active-high segment table constants,
//    hex2seg function.
//  - Sub-module md_hex2seg (4-bit in, 7-bit active-high out, combinational);
//    polarity inversion and blanking stay in the top block.
// TESTING (bench with SCAN_DIV=4, DEAD_CYC=1, ACTIVE_LOW=1, BLANK_LZ=1)
//  1 rst high 3 cycles -> an=4'hF, seg=7'h7F, dp=1, frame_done=0; after release
//    slot0 shows "0": an=4'hE from 2nd slot cycle, seg=7'h40.
//  2 din=16'h1234 pulse in slot1 -> unchanged until wrap; after frame_done digit0
//    seg=7'h19 (4), digit3 seg=7'h79 (1), an cycles E,D,B,7.
//  3 din=16'h0050 -> digits 3,2 seg=7'h7F with an driven, digit1 seg=7'h12 (5),
//    digit0 seg=7'h40 (0).
//  4 din_valid in the wrap cycle with din=16'hABCD -> next frame shows ABCD
//    (digit0 seg=7'h21), no one-frame delay.
//  5 two din_valid pulses in one frame (16'h1111 then 16'h2222) -> only 2222
//    ever displayed; frame_done pulse width exactly 1 cycle every 16 cycles.
//  6 rst asserted in slot 2 after pending write -> reset values next edge; next
//    frame shows 0 (pending discarded).

Source files
------------

// File: rtl/md_seg_scan_4digit_pkg.sv
// Shared constants, buffer type and hex-to-segment decode for the 4-digit scanner.
package md_seg_pkg;

  localparam int NUM_DIG = 4;
  localparam int NUM_HEX = 16;

  // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by hex value 0..F.
  localparam logic [6:0] SEG_TABLE [NUM_HEX] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One display image: four hex digits plus their decimal points.
  typedef struct packed {
    logic [4*NUM_DIG-1:0] dig;
    logic [NUM_DIG-1:0]   dp;
  } disp_buf_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/md_seg_scan_4digit_hex2seg.sv
// Combinational hex digit to active-high 7-segment pattern.
module md_hex2seg
  import md_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/md_seg_scan_4digit.sv
// 4-digit multiplexed 7-segment scanner with frame-aligned double buffering.
module md_seg_scan_4digit
  import md_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEAD_CYC   = 2,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_LIM = DIV_W'(DEAD_CYC);
  localparam logic [NUM_DIG-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]         SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic               DP_OFF  = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]         idx_q, idx_d;
  disp_buf_t          pending_q, pending_d;
  disp_buf_t          committed_q, committed_d;
  logic               frame_done_q, frame_done_d;
  logic [NUM_DIG-1:0] an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               slot_end;
  logic               frame_wrap;
  logic [3:0]         cur_dig;
  logic [6:0]         cur_seg;
  logic [NUM_DIG-1:0] blank;

  assign cur_dig = committed_q.dig[{idx_q, 2'b00} +: 4];

  md_hex2seg u_hex2seg (
    .hex_i (cur_dig),
    .seg_o (cur_seg)
  );

  // Leading-zero mask: digit k blanks when it and every higher digit are zero.
  always_comb begin
    logic lz;
    blank = '0;
    lz    = 1'b1;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      lz       = lz & (committed_q.dig[4*k +: 4] == 4'h0);
      blank[k] = lz & (BLANK_LZ != 0);
    end
  end

  // Scan divider, buffer commit at the 3->0 wrap, and next output image.
  always_comb begin
    logic [NUM_DIG-1:0] an_on;
    logic [6:0]         seg_on;

    slot_end   = (div_cnt_q == DIV_LAST);
    frame_wrap = slot_end && (idx_q == 2'd3);

    div_cnt_d = slot_end ? '0 : div_cnt_q + DIV_W'(1);
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

    // Routing commit through pending_d gives the same-cycle bypass for free.
    pending_d = pending_q;
    if (din_valid) begin
      pending_d.dig = din;
      pending_d.dp  = dp_in;
    end
    committed_d  = frame_wrap ? pending_d : committed_q;
    frame_done_d = frame_wrap;

    an_on  = (div_cnt_q < DEAD_LIM) ? '0 : (NUM_DIG'(1) << idx_q);
    seg_on = blank[idx_q] ? 7'h00 : cur_seg;

    an_d  = (ACTIVE_LOW != 0) ? ~an_on  : an_on;
    seg_d = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
    dp_d  = (ACTIVE_LOW != 0) ? ~committed_q.dp[idx_q] : committed_q.dp[idx_q];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      committed_q  <= '0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      committed_q  <= committed_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_md_seg_scan_4digit.sv
// Self-checking bench for md_seg_scan_4digit (SCAN_DIV=4, DEAD_CYC=1, active-low, blanking on).
module tb_md_seg_scan_4digit;

  localparam int SCAN_DIV = 4;
  localparam int DEAD_CYC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [15:0] model_pend, model_comm;
  logic [3:0]  mdp_pend, mdp_comm;

  // Active-high reference patterns; the display is active-low so the bench inverts.
  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  md_seg_scan_4digit #(
    .SCAN_DIV   (SCAN_DIV),
    .DEAD_CYC   (DEAD_CYC),
    .ACTIVE_LOW (1),
    .BLANK_LZ   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // Expected 16 output cycles of one frame showing image d/dpv.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv);
    int          k, c;
    logic [15:0] upper;
    logic [3:0]  dig;
    logic        blnk;
    exp_t        e;
    for (int n = 1; n <= 16; n++) begin
      k     = (n - 1) / 4;
      c     = (n - 1) % 4;
      upper = d >> (4 * k);
      dig   = upper[3:0];
      blnk  = (k > 0) && (upper == 16'h0000);
      e.an  = (c < DEAD_CYC) ? 4'hF : ~(4'b0001 << k);
      e.seg = blnk ? 7'h7F : ~seg_tbl[dig];
      e.dp  = ~dpv[k];
      e.fd  = (n == 16);
      sb_q.push_back(e);
    end
  endtask

  // Runs one full frame from a frame_done cycle to the next, with up to two pending writes.
  task automatic run_frame(input string name,
                           input int pa, input logic [15:0] va, input logic [3:0] dpa,
                           input int pb, input logic [15:0] vb, input logic [3:0] dpb);
    exp_t e;
    push_frame(model_comm, mdp_comm);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (an !== e.an) begin
        errors++;
        $display("FAIL %s an n=%0d: got %h expected %h", name, n, an, e.an);
      end
      checks++;
      if (seg !== e.seg) begin
        errors++;
        $display("FAIL %s seg n=%0d: got %h expected %h", name, n, seg, e.seg);
      end
      checks++;
      if (dp !== e.dp) begin
        errors++;
        $display("FAIL %s dp n=%0d: got %b expected %b", name, n, dp, e.dp);
      end
      checks++;
      if (frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s frame_done n=%0d: got %b expected %b", name, n, frame_done, e.fd);
      end
      din_valid = 1'b0;
      if (n == pa) begin
        din_valid = 1'b1; din = va; dp_in = dpa;
        model_pend = va; mdp_pend = dpa;
      end
      if (n == pb) begin
        din_valid = 1'b1; din = vb; dp_in = dpb;
        model_pend = vb; mdp_pend = dpb;
      end
    end
    model_comm = model_pend;
    mdp_comm   = mdp_pend;
  endtask

  // Bounded wait for the next frame_done pulse.
  task automatic sync_frame(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s sync: got no frame_done within 40 cycles, expected a pulse", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b0; din = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: got an=%h seg=%h dp=%b fd=%b expected an=f seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    rst = 1'b0;
    model_pend = '0; model_comm = '0; mdp_pend = '0; mdp_comm = '0;
    @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h40) begin
      errors++;
      $display("FAIL reset_slot0_dead: got an=%h seg=%h expected an=f seg=40", an, seg);
    end
    @(negedge clk);
    checks++;
    if (an !== 4'hE || seg !== 7'h40 || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_slot0_on: got an=%h seg=%h dp=%b expected an=e seg=40 dp=1", an, seg, dp);
    end
    for (int n = 3; n <= 16; n++) begin
      @(negedge clk);
      checks++;
      if (frame_done !== (n == 16)) begin
        errors++;
        $display("FAIL reset_first_frame_done n=%0d: got %b expected %b", n, frame_done, (n == 16));
      end
    end
    if (frame_done !== 1'b1) sync_frame("reset_resync");
  endtask

  task automatic test_idle();
    run_frame("idle_zero", 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_update();
    run_frame("update_hold", 5, 16'h1234, 4'b0100, 0, '0, '0);
    run_frame("update_show", 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_blank();
    run_frame("blank_write", 8, 16'h0050, 4'b1000, 0, '0, '0);
    run_frame("blank_show", 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_bypass();
    run_frame("bypass_write", 15, 16'hABCD, 4'b0001, 0, '0, '0);
    run_frame("bypass_show", 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_write", 3, 16'h1111, 4'b0010, 10, 16'h2222, 4'b0000);
    run_frame("b2b_show", 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_reset_midframe();
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      din_valid = 1'b0;
      if (n == 2) begin
        din_valid = 1'b1; din = 16'h9876; dp_in = 4'b1111;
      end
      if (n == 9) rst = 1'b1;
    end
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_vals: got an=%h seg=%h dp=%b fd=%b expected an=f seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_pend = '0; model_comm = '0; mdp_pend = '0; mdp_comm = '0;
    sync_frame("midreset_sync");
    run_frame("midreset_discard", 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    din_valid = 1'b0;
    din = '0;
    dp_in = '0;
    test_reset();
    test_idle();
    test_update();
    test_blank();
    test_bypass();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
